triple_buffer_ctrl: RTL and testbench

- Owns the three DDR frame rooms shared by the camera write path and the HDMI read path.
- Publishes the base address the AXI writer uses and the base address the AXI reader uses.
- Rotates rooms on camera end-of-frame and display vsync, so the reader never sees a partially written frame and the writer never overwrites the frame on screen.
- Keeps frame, drop and repeat statistics for ILA/VIO debug.

---
 rtl/triple_buffer_ctrl.sv | 141 ++++++++++++++
 tb/tb_triple_buffer_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/triple_buffer_ctrl.sv
// ---------------------------------------------------------------------------
// triple_buffer_ctrl
//   Owns three DDR frame rooms shared by the camera write path and the HDMI
//   read path. Rotates rooms on camera end-of-frame and display vsync so the
//   reader never sees a half-written frame and the writer never overwrites
//   the room on screen. Keeps frame/drop/repeat statistics for debug.
//
// Ports
//   clk_100Mhz      AXI-domain clock (only clock in this block)
//   rst_n           asynchronous active-low reset
//   cam_vsync       raw camera vsync, asynchronous; high = vertical blanking
//   rd_vsync_pulse  one-cycle display frame-start pulse (clk_100Mhz domain)
//   wr_base_addr    room base address for the AXI writer
//   rd_base_addr    room base address for the AXI reader
//   wr_frame_done   one-cycle pulse when a write room is retired
//   fresh_valid     a completed frame is waiting for the reader
//   frame_cnt       completed write frames (saturating)
//   drop_cnt        completed frames discarded unread (saturating)
//   repeat_cnt      display frames that re-showed the previous room (saturating)
// ---------------------------------------------------------------------------
module triple_buffer_ctrl #(
  parameter logic [31:0] BASE_ADDR   = 32'h0100_0000,
  parameter logic [31:0] ROOM_STRIDE = 32'h0010_0000,
  parameter int          CNT_W       = 16
) (
  input  logic             clk_100Mhz,
  input  logic             rst_n,
  input  logic             cam_vsync,
  input  logic             rd_vsync_pulse,
  output logic [31:0]      wr_base_addr,
  output logic [31:0]      rd_base_addr,
  output logic             wr_frame_done,
  output logic             fresh_valid,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [CNT_W-1:0] repeat_cnt
);

  typedef enum logic {WAIT_SOF, RUN} state_t;

  state_t     state;
  logic [1:0] w_idx, r_idx, latest_idx;
  logic       latest_valid;

  logic [1:0] w_nxt, r_nxt, l_nxt, third;
  logic       lv_nxt;

  logic vs_s1, vs_s2, vs_s3;
  logic sof, eof, eof_ok;

  function automatic logic [31:0] room_addr(input logic [1:0] idx);
    return BASE_ADDR + ROOM_STRIDE * {30'd0, idx};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + CNT_W'(1);
  endfunction

  // Synchroniser resets high so a vsync already in blanking at reset
  // release does not look like a rising edge.
  always_ff @(posedge clk_100Mhz or negedge rst_n) begin
    if (!rst_n) begin
      vs_s1 <= 1'b1;
      vs_s2 <= 1'b1;
      vs_s3 <= 1'b1;
    end else begin
      vs_s1 <= cam_vsync;
      vs_s2 <= vs_s1;
      vs_s3 <= vs_s2;
    end
  end

  assign sof    = ~vs_s2 &  vs_s3;
  assign eof    =  vs_s2 & ~vs_s3;
  assign eof_ok = eof & (state == RUN);

  // The three indices always form a permutation-like set, so the free room
  // is whatever is left of 0+1+2.
  assign third = 2'd3 - w_idx - r_idx;

  always_comb begin
    w_nxt  = w_idx;
    r_nxt  = r_idx;
    l_nxt  = latest_idx;
    lv_nxt = latest_valid;
    if (eof_ok) begin
      w_nxt = third;
      l_nxt = w_idx;
      if (rd_vsync_pulse) begin
        // Reader grabs the room that just completed in the same cycle.
        r_nxt  = w_idx;
        lv_nxt = 1'b0;
      end else begin
        lv_nxt = 1'b1;
      end
    end else if (rd_vsync_pulse && latest_valid) begin
      r_nxt  = latest_idx;
      lv_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk_100Mhz or negedge rst_n) begin
    if (!rst_n) begin
      state         <= WAIT_SOF;
      w_idx         <= 2'd0;
      r_idx         <= 2'd2;
      latest_idx    <= 2'd2;
      latest_valid  <= 1'b0;
      wr_base_addr  <= BASE_ADDR;
      rd_base_addr  <= BASE_ADDR + 2 * ROOM_STRIDE;
      wr_frame_done <= 1'b0;
      fresh_valid   <= 1'b0;
      frame_cnt     <= '0;
      drop_cnt      <= '0;
      repeat_cnt    <= '0;
    end else begin
      case (state)
        WAIT_SOF: if (sof) state <= RUN;
        RUN:      state <= RUN;
        default:  state <= WAIT_SOF;
      endcase

      w_idx         <= w_nxt;
      r_idx         <= r_nxt;
      latest_idx    <= l_nxt;
      latest_valid  <= lv_nxt;
      wr_base_addr  <= room_addr(w_nxt);
      rd_base_addr  <= room_addr(r_nxt);
      wr_frame_done <= eof_ok;
      fresh_valid   <= lv_nxt;

      if (eof_ok)
        frame_cnt <= sat_inc(frame_cnt);
      if (eof_ok && latest_valid)
        drop_cnt <= sat_inc(drop_cnt);
      if (rd_vsync_pulse && !eof_ok && !latest_valid)
        repeat_cnt <= sat_inc(repeat_cnt);
    end
  end

endmodule

// File: tb/tb_triple_buffer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_triple_buffer_ctrl
//   Directed plus randomised stimulus for triple_buffer_ctrl. A behavioural
//   room model pushes expected outputs into a scoreboard queue when an event
//   is driven; entries are popped and compared once the DUT has reacted.
//   A second instance with 4-bit counters exercises saturation.
// ---------------------------------------------------------------------------
module tb_triple_buffer_ctrl;

  logic        clk_100Mhz;
  logic        rst_n;
  logic        cam_vsync;
  logic        rd_vsync_pulse;
  logic [31:0] wr_base_addr, rd_base_addr;
  logic        wr_frame_done, fresh_valid;
  logic [15:0] frame_cnt, drop_cnt, repeat_cnt;

  logic [31:0] s_wr, s_rd;
  logic        s_done, s_fresh;
  logic [3:0]  s_frame, s_drop, s_rep;

  triple_buffer_ctrl u_dut (
    .clk_100Mhz     (clk_100Mhz),
    .rst_n          (rst_n),
    .cam_vsync      (cam_vsync),
    .rd_vsync_pulse (rd_vsync_pulse),
    .wr_base_addr   (wr_base_addr),
    .rd_base_addr   (rd_base_addr),
    .wr_frame_done  (wr_frame_done),
    .fresh_valid    (fresh_valid),
    .frame_cnt      (frame_cnt),
    .drop_cnt       (drop_cnt),
    .repeat_cnt     (repeat_cnt)
  );

  triple_buffer_ctrl #(.CNT_W(4)) u_sat (
    .clk_100Mhz     (clk_100Mhz),
    .rst_n          (rst_n),
    .cam_vsync      (cam_vsync),
    .rd_vsync_pulse (rd_vsync_pulse),
    .wr_base_addr   (s_wr),
    .rd_base_addr   (s_rd),
    .wr_frame_done  (s_done),
    .fresh_valid    (s_fresh),
    .frame_cnt      (s_frame),
    .drop_cnt       (s_drop),
    .repeat_cnt     (s_rep)
  );

  initial clk_100Mhz = 1'b0;
  always #5 clk_100Mhz = ~clk_100Mhz;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  typedef struct packed {
    logic [31:0] wr;
    logic [31:0] rd;
    logic        fresh;
    logic [15:0] frame;
    logic [15:0] drop;
    logic [15:0] rep;
  } exp_t;

  exp_t sb[$];
  int m_w, m_r, m_lat, m_lv, m_frame, m_drop, m_rep;

  function automatic logic [31:0] room(input int i);
    return 32'h0100_0000 + 32'(i) * 32'h0010_0000;
  endfunction

  function automatic logic [15:0] sat16(input int v);
    return (v > 65535) ? 16'hFFFF : 16'(v);
  endfunction

  function automatic logic [31:0] sat4(input int v);
    return (v > 15) ? 32'd15 : 32'(v);
  endfunction

  task automatic push_exp();
    exp_t e;
    e.wr    = room(m_w);
    e.rd    = room(m_r);
    e.fresh = (m_lv != 0);
    e.frame = sat16(m_frame);
    e.drop  = sat16(m_drop);
    e.rep   = sat16(m_rep);
    sb.push_back(e);
  endtask

  task automatic model_reset();
    m_w = 0; m_r = 2; m_lat = 2; m_lv = 0;
    m_frame = 0; m_drop = 0; m_rep = 0;
    push_exp();
  endtask

  task automatic model_eof();
    int t;
    t = 3 - m_w - m_r;
    if (m_lv != 0) m_drop++;
    m_lat = m_w; m_lv = 1; m_w = t; m_frame++;
    push_exp();
  endtask

  task automatic model_rd();
    if (m_lv != 0) begin m_r = m_lat; m_lv = 0; end
    else m_rep++;
    push_exp();
  endtask

  task automatic model_both();
    int t;
    t = 3 - m_w - m_r;
    if (m_lv != 0) m_drop++;
    m_r = m_w; m_lat = m_w; m_lv = 0; m_w = t; m_frame++;
    push_exp();
  endtask

  task automatic compare_state(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, " sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    chk({tag, " wr_base"},  wr_base_addr,        e.wr);
    chk({tag, " rd_base"},  rd_base_addr,        e.rd);
    chk({tag, " fresh"},    {31'd0, fresh_valid}, {31'd0, e.fresh});
    chk({tag, " frame"},    {16'd0, frame_cnt},  {16'd0, e.frame});
    chk({tag, " drop"},     {16'd0, drop_cnt},   {16'd0, e.drop});
    chk({tag, " repeat"},   {16'd0, repeat_cnt}, {16'd0, e.rep});
  endtask

  // ---------------- stimulus helpers (drive and sample on negedge) ----------------
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk_100Mhz);
  endtask

  // Raise cam_vsync (eof), optionally aligning a display pulse with the eof
  // strobe, then return to active video after hi/lo cycles.
  task automatic cam_frame(input bit both, input int hi, input int lo, input string tag);
    int lat;
    lat = 0;
    cam_vsync = 1'b1;
    do begin
      @(negedge clk_100Mhz);
      lat++;
      rd_vsync_pulse = both && (lat == 2);
    end while (!wr_frame_done && lat < 10);
    rd_vsync_pulse = 1'b0;
    chk({tag, " eof_latency"}, 32'(lat), 32'd3);
    if (wr_frame_done) begin
      if (both) model_both(); else model_eof();
      compare_state(tag);
    end
    tick(1);
    chk({tag, " done_width"}, {31'd0, wr_frame_done}, 32'd0);
    tick(hi);
    cam_vsync = 1'b0;
    tick(lo);
  endtask

  task automatic rd_event(input string tag);
    rd_vsync_pulse = 1'b1;
    tick(1);
    rd_vsync_pulse = 1'b0;
    model_rd();
    compare_state(tag);
  endtask

  // Writer and reader must never share a room while out of reset.
  always @(negedge clk_100Mhz) begin
    if (rst_n === 1'b1)
      chk("invariant wr_ne_rd", {31'd0, wr_base_addr != rd_base_addr}, 32'd1);
  end

  initial begin
    rst_n          = 1'b0;
    cam_vsync      = 1'b1;
    rd_vsync_pulse = 1'b0;
    tick(3);
    model_reset();
    compare_state("reset");
    chk("reset done", {31'd0, wr_frame_done}, 32'd0);

    // Release in blanking: no edge, no eof.
    rst_n = 1'b1;
    tick(6);
    push_exp();
    compare_state("wait_sof idle");
    cam_vsync = 1'b0;
    tick(6);
    cam_frame(1'b0, 2, 5, "first_eof");

    rd_event("first_rd");
    cam_frame(1'b0, 2, 5, "second_eof");

    // Second eof with no read between -> drop, reader gets the newer room.
    cam_frame(1'b0, 2, 5, "drop_eof");
    chk("drop_eof rd_target", room(m_lat), 32'h0120_0000);
    rd_event("drop_rd");

    for (int i = 0; i < 3; i++) rd_event("repeat_rd");

    // Asynchronous reset in the middle of an eof in flight.
    cam_vsync = 1'b1;
    tick(1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_state("async_reset");
    chk("async_reset done", {31'd0, wr_frame_done}, 32'd0);
    tick(3);
    rst_n = 1'b1;
    tick(4);
    rd_event("wait_sof repeat");
    cam_vsync = 1'b0;
    tick(6);
    cam_frame(1'b0, 2, 5, "re_eof");
    rd_event("re_rd");

    // w_idx=1, r_idx=0: eof and display pulse together.
    chk("pre_both w", room(m_w), 32'h0110_0000);
    cam_frame(1'b1, 2, 5, "both");

    // Randomised run with jittered vsync timing.
    for (int f = 0; f < 2000; f++) begin
      cam_frame($urandom_range(0, 7) == 0, $urandom_range(1, 4),
                $urandom_range(4, 8), "rand_eof");
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
        tick($urandom_range(0, 2));
        rd_event("rand_rd");
      end
    end

    chk("sat frame",  {28'd0, s_frame}, sat4(m_frame));
    chk("sat drop",   {28'd0, s_drop},  sat4(m_drop));
    chk("sat repeat", {28'd0, s_rep},   sat4(m_rep));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
